// File: rtl/mux4_arb_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
package mux4_arb_pkg;
  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;
endpackage

// File: rtl/mux4_rr_pick.sv
// Combinational rotating-priority picker: first set request scanning ptr, ptr+1, ... mod 4.
module mux4_rr_pick
  import mux4_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;
  logic             found;

  always_comb begin
    idx   = ptr;
    cand  = ptr;
    found = 1'b0;
    // Index arithmetic wraps naturally in SEL_W bits.
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr + SEL_W'(k);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving a 4:1 data mux with valid/ready output and per-requester ack.
// Optional burst hold (lock port) is enabled by defining MUX4_ARB_LOCK_EN.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [DW-1:0]     a,
  input  logic [DW-1:0]     b,
  input  logic [DW-1:0]     c,
  input  logic [DW-1:0]     d,
`ifdef MUX4_ARB_LOCK_EN
  input  logic [NREQ-1:0]   lock,
`endif
  output logic [DW-1:0]     out,
  output logic [SEL_W-1:0]  sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   ack
);

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             vld_q, vld_d;
  logic [NREQ-1:0]  grant_q, grant_d;

  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic             hs;
  logic             hold;

  mux4_rr_pick u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign hs = vld_q & out_ready;

`ifdef MUX4_ARB_LOCK_EN
  assign hold = lock[sel_q] & req[sel_q];
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    vld_d   = vld_q;
    grant_d = grant_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          sel_d   = pick_idx;
          grant_d = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
          vld_d   = 1'b1;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        // A locked handshake keeps sel and ptr so the same requester streams its next word.
        if (hs && !hold) begin
          ptr_d   = sel_q + SEL_W'(1);
          vld_d   = 1'b0;
          grant_d = '0;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      vld_q   <= 1'b0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      vld_q   <= vld_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    out = a;
    case (sel_q)
      2'd0: out = a;
      2'd1: out = b;
      2'd2: out = c;
      2'd3: out = d;
      default: out = a;
    endcase
  end

  assign sel       = sel_q;
  assign out_valid = vld_q;
  assign grant     = grant_q;
  assign ack       = grant_q & {NREQ{hs}};

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_mux4_rr_arbiter;
  localparam int DW = 4;
`ifdef MUX4_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req;
  logic [DW-1:0] a, b, c, d;
  logic [3:0]    lock;
  logic [DW-1:0] out;
  logic [1:0]    sel;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    grant;
  logic [3:0]    ack;

  int checks = 0;
  int errors = 0;

  // Behavioural model state: busy flag, priority pointer, current owner.
  bit            m_busy;
  int            m_ptr;
  int            m_sel;
  logic          e_vld;
  logic [1:0]    e_sel;
  logic [3:0]    e_grant;
  logic [3:0]    e_ack;
  logic [DW-1:0] e_out;

  mux4_rr_arbiter #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
`ifdef MUX4_ARB_LOCK_EN
    .lock      (lock),
`endif
    .out       (out),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant     (grant),
    .ack       (ack)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, actual running required finished");
    $fatal(1, "watchdog");
  end

  task automatic calc();
    e_vld   = m_busy;
    e_sel   = m_sel[1:0];
    e_grant = m_busy ? (4'b0001 << m_sel) : 4'b0000;
    e_ack   = (m_busy && out_ready) ? e_grant : 4'b0000;
    case (m_sel)
      0: e_out = a;
      1: e_out = b;
      2: e_out = c;
      default: e_out = d;
    endcase
  endtask

  // Advance the model across the coming edge with the inputs currently driven, then step the clock.
  task automatic tick();
    bit found;
    if (rst) begin
      m_busy = 1'b0; m_ptr = 0; m_sel = 0;
    end else if (!m_busy) begin
      if (req != 4'b0000) begin
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
          if (!found && req[(m_ptr + k) % 4]) begin
            m_sel = (m_ptr + k) % 4;
            found = 1'b1;
          end
        end
        m_busy = 1'b1;
      end
    end else if (out_ready) begin
      if (!(LOCK_EN && lock[m_sel] && req[m_sel])) begin
        m_ptr  = (m_sel + 1) % 4;
        m_busy = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; lock = '0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      out_ready = (i >= 5);
      #2;
      checks++;
      if ({out_valid, grant, sel, ack} !== 11'b0) begin
        errors++;
        $display("FAIL reset_idle cyc%0d: got vld=%b grant=%b sel=%b ack=%b, want all zero",
                 i, out_valid, grant, sel, ack);
      end
      tick();
    end
  endtask

  task automatic test_single();
    do_reset();
    a = 4'd1; b = 4'd2; c = 4'd3; d = 4'd4;
    req = 4'b0010; out_ready = 1'b1;
    #2;
    checks++;
    if (out_valid !== 1'b0 || ack !== 4'b0000) begin
      errors++;
      $display("FAIL single_idle: got vld=%b ack=%b, want 0/0000", out_valid, ack);
    end
    tick();
    #2;
    checks++;
    if (sel !== 2'b01 || out !== 4'd2 || out_valid !== 1'b1 || ack !== 4'b0010 || grant !== 4'b0010) begin
      errors++;
      $display("FAIL single_beat: got sel=%b out=%0d vld=%b ack=%b grant=%b, want 01/2/1/0010/0010",
               sel, out, out_valid, ack, grant);
    end
    tick();
    req = 4'b1111;
    #2;
    checks++;
    if (out_valid !== 1'b0 || ack !== 4'b0000) begin
      errors++;
      $display("FAIL single_gap: got vld=%b ack=%b, want 0/0000", out_valid, ack);
    end
    tick();
    #2;
    checks++;
    if (sel !== 2'b10) begin
      errors++;
      $display("FAIL single_ptr: next winner sel=%b, want 10", sel);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_all_req();
    int idx;
    do_reset();
    a = 4'd1; b = 4'd2; c = 4'd3; d = 4'd4;
    req = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #2;
      checks++;
      if (i % 2 == 0) begin
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL all_gap cyc%0d: got vld=%b, want 0", i, out_valid);
        end
      end else begin
        idx = ((i - 1) / 2) % 4;
        if (sel !== idx[1:0] || out !== DW'(idx + 1) || ack !== (4'b0001 << idx)) begin
          errors++;
          $display("FAIL all_order cyc%0d: got sel=%0d out=%0d ack=%b, want %0d/%0d/%b",
                   i, sel, out, ack, idx, idx + 1, 4'b0001 << idx);
        end
      end
      tick();
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    a = 4'd1; b = 4'd2; c = 4'd3; d = 4'd4;
    req = 4'b0100; out_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      #2;
      checks++;
      if (out_valid !== 1'b1 || sel !== 2'b10 || out !== 4'd3 || ack !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold cyc%0d: got vld=%b sel=%b out=%0d ack=%b, want 1/10/3/0000",
                 i, out_valid, sel, out, ack);
      end
      tick();
    end
    out_ready = 1'b1;
    #2;
    checks++;
    if (ack !== 4'b0100 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got ack=%b vld=%b, want 0100/1", ack, out_valid);
    end
    tick();
    req = 4'b0000;
    #2;
    checks++;
    if (ack !== 4'b0000 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_after: got ack=%b vld=%b, want 0000/0", ack, out_valid);
    end
    tick();
  endtask

  task automatic test_rst_busy();
    do_reset();
    req = 4'b1000; out_ready = 1'b0;
    tick();
    #2;
    checks++;
    if (sel !== 2'b11 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstb_setup: got sel=%b vld=%b, want 11/1", sel, out_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; req = 4'b0000; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      checks++;
      if ({out_valid, grant, sel, ack} !== 11'b0) begin
        errors++;
        $display("FAIL rstb_after cyc%0d: got vld=%b grant=%b sel=%b ack=%b, want all zero",
                 i, out_valid, grant, sel, ack);
      end
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 59) == 0);
      req       = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      lock      = 4'($urandom);
      a = DW'($urandom); b = DW'($urandom); c = DW'($urandom); d = DW'($urandom);
      #2;
      calc();
      checks++;
      if ({out_valid, sel, grant, ack, out} !== {e_vld, e_sel, e_grant, e_ack, e_out}) begin
        errors++;
        $display("FAIL rand cyc%0d: got vld=%b sel=%b grant=%b ack=%b out=%h, want %b/%b/%b/%b/%h",
                 i, out_valid, sel, grant, ack, out, e_vld, e_sel, e_grant, e_ack, e_out);
      end
      tick();
    end
    rst = 1'b0; lock = '0;
  endtask

`ifdef MUX4_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    req = 4'b0101; lock = 4'b0001; out_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      a = DW'(i + 5);
      if (i == 2) lock = 4'b0000;
      #2;
      checks++;
      if (out_valid !== 1'b1 || sel !== 2'b00 || out !== DW'(i + 5) || ack !== 4'b0001) begin
        errors++;
        $display("FAIL lock_beat%0d: got vld=%b sel=%b out=%0d ack=%b, want 1/00/%0d/0001",
                 i, out_valid, sel, out, ack, i + 5);
      end
      tick();
    end
    req = 4'b0100;
    #2;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL lock_gap: got vld=%b, want 0", out_valid);
    end
    tick();
    #2;
    checks++;
    if (sel !== 2'b10 || grant !== 4'b0100) begin
      errors++;
      $display("FAIL lock_next: got sel=%b grant=%b, want 10/0100", sel, grant);
    end
    req = 4'b0000;
    tick();
  endtask
`endif

  initial begin
    rst = 1'b1; req = '0; lock = '0; out_ready = 1'b0;
    a = '0; b = '0; c = '0; d = '0;
    m_busy = 1'b0; m_ptr = 0; m_sel = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_all_req();
    test_backpressure();
    test_rst_busy();
`ifdef MUX4_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

- Round-robin arbiter and sequencer that shares one 4-bit output channel among four requesters.
- Picks a winner and drives the 2-bit select of a 4:1 data mux.
- Presents the selected word with a valid/ready handshake and returns a per-requester acknowledge.
- Sits in front of the 4:1 mux datapath and replaces the free-running `sel` stimulus with fair, handshake-driven selection.

## Interface
- `DW`, 4, data width per requester and of the output.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous reset, active-high.
- `req`  in  4  per-requester request; bit i = requester i (a=0, b=1, c=2, d=3).
- `a`, `b`, `c`, `d`  in  DW each  requester data; must stay stable while its `req` is high and not yet acked.
- `lock`  in  4  burst-hold request per requester (present only with `MUX4_ARB_LOCK_EN`).
- `out`  out  DW  selected data: the mux of `a`..`d` by `sel`; combinational from the registered `sel`.
- `sel`  out  2  registered grant index.
- `out_valid`  out  1  registered; `out` holds a valid beat.
- `out_ready`  in  1  downstream accepts the beat when high together with `out_valid`.
- `grant`  out  4  registered one-hot of `sel`, qualified by BUSY; 0 in IDLE.
- `ack`  out  4  combinational one-hot: `grant & {4{out_valid & out_ready}}`.

## Operation
- FSM states: IDLE and BUSY. Pointer `ptr[1:0]` marks the highest-priority requester.
- IDLE, `req==0`: stay in IDLE; `out_valid=0`, `grant=0`.
- IDLE, `req!=0`: winner is the first set bit scanning `ptr, ptr+1, …` mod 4. Register `sel=winner`, set `grant[winner]`, `out_valid=1`, go to BUSY.
- BUSY, no handshake: hold `sel`, `grant` and `out_valid`. A requester dropping `req` while granted does not cancel the beat; the beat completes on the handshake.
- BUSY, handshake (`out_valid & out_ready`): `ack[sel]` pulses for that cycle only. Then `ptr <= sel+1` (3 wraps to 0), `out_valid <= 0`, `grant <= 0`, go to IDLE.
- The IDLE cycle after every grant lets the requester update `req` after seeing `ack`. Throughput without lock is 1 beat per 2 cycles.
- `sel` keeps its last value in IDLE, so `out` stays defined.
- Simultaneous requests: resolved strictly by the rotating pointer. No requester waits more than 3 grants.

## Timing
- Reset values: state IDLE, `ptr=0`, `sel=0`, `out_valid=0`, `grant=0`, `ack=0`.
- Latency: `req` high in an IDLE cycle N puts `out_valid=1` and the new `sel` on cycle N+1.
- `out` follows `sel` and the data inputs combinationally: zero added latency.
- `ack` is combinational in the handshake cycle. The requester updates `req` and data at that clock edge.
- `rst` mid-BUSY: the next edge returns everything to reset values. The pending beat is dropped and no `ack` is issued after reset.
- `out_ready` high in IDLE: no effect.

## Configuration
- `MUX4_ARB_LOCK_EN` defined:
  - `lock` port exists.
  - On a handshake with `lock[sel] & req[sel]`: stay in BUSY, `out_valid` stays 1, `sel` and `ptr` are unchanged, and the requester presents its next word in the following cycle. Throughput is 1 beat per cycle.
  - Deasserting `lock` makes the next handshake the last one of the burst; normal release follows.
  - A locked burst may starve other requesters; that is accepted.
- `MUX4_ARB_LOCK_EN` undefined: no `lock` port, and every grant is exactly one beat.

## Structure
- Shared package `mux4_arb_pkg`: the state typedef (`ARB_IDLE`, `ARB_BUSY`), `NREQ=4`, and the select width constant 2.
- Sub-module `mux4_rr_pick`: combinational rotating-priority picker.
  - Inputs: `req[3:0]`, `ptr[1:0]`.
  - Outputs: `any`, `idx[1:0]`.
- The top module holds the FSM, the registers and the 4:1 output mux.

## Test plan
- Reset, then `req=0000` for 10 cycles → `out_valid=0`, `grant=0000`, `sel=00`, `ack=0000` throughout.
- `a=1, b=2, c=3, d=4`, `req=0010`, `out_ready=1` → next cycle `sel=01`, `out=2`, `out_valid=1`, `ack=0010` that cycle; then one IDLE cycle; `ptr=2`.
- `req=1111` held, `out_ready=1` → grant order 0,1,2,3,0, and `out` sequence 1,2,3,4,1 on alternate cycles.
- `req=0100`, `out_ready=0` for 5 cycles then 1 → `sel=10`, `out=3`; `out_valid` held 5 cycles; single `ack=0100` on the release cycle.
- `rst` asserted while BUSY with `sel=11` → next cycle all outputs at reset values, and no `ack` on any later cycle until a new request.
- With `MUX4_ARB_LOCK_EN`: `req=0001`, `lock=0001` for 3 beats, `req[2]` also high → three consecutive beats from `a` with `out_valid` continuous; the grant moves to 2 only after `lock` drops.
